// File: rtl/snake_pkg.sv
// Shared encodings, board limits and LFSR constants for the snake game controller.
// SCORE_BCD_EN additionally provides the BCD increment helper.
package snake_pkg;

    typedef enum logic [1:0] {
        MSM_START = 2'b00,
        MSM_PLAY  = 2'b01,
        MSM_LOST  = 2'b10,
        MSM_WIN   = 2'b11
    } msm_e;

    typedef enum logic [1:0] {
        NAV_UP    = 2'b00,
        NAV_LEFT  = 2'b01,
        NAV_RIGHT = 2'b10,
        NAV_DOWN  = 2'b11
    } nav_e;

    localparam int unsigned BOARD_MAX_X = 159;
    localparam int unsigned BOARD_MAX_Y = 119;

    // x^15 + x^14 + 1 : feedback from the two top stages
    localparam int unsigned LFSR_W      = 15;
    localparam int unsigned LFSR_TAP_HI = 14;
    localparam int unsigned LFSR_TAP_LO = 13;

    localparam logic [7:0] TARGET_H_RST = 8'd40;
    localparam logic [6:0] TARGET_V_RST = 7'd30;

`ifdef SCORE_BCD_EN
    function automatic logic [11:0] bcd_inc(input logic [11:0] v);
        logic [11:0] r;
        r = v;
        if (r[3:0] == 4'd9) begin
            r[3:0] = '0;
            if (r[7:4] == 4'd9) begin
                r[7:4]  = '0;
                r[11:8] = r[11:8] + 4'd1;
            end else begin
                r[7:4] = r[7:4] + 4'd1;
            end
        end else begin
            r[3:0] = r[3:0] + 4'd1;
        end
        return r;
    endfunction
`endif

endpackage

// File: rtl/snake_target_lfsr.sv
// Free-running target LFSR; on REQ it keeps drawing candidates until one lands
// inside the board and then loads it as the new target.
module snake_target_lfsr #(
    parameter int unsigned MAX_X     = snake_pkg::BOARD_MAX_X,
    parameter int unsigned MAX_Y     = snake_pkg::BOARD_MAX_Y,
    parameter logic [14:0] LFSR_SEED = 15'h4A5F
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       REQ,
    output logic [7:0] TARGET_ADDR_H,
    output logic [6:0] TARGET_ADDR_V
);
    import snake_pkg::*;

    localparam logic [7:0] MAX_H = 8'(MAX_X);
    localparam logic [6:0] MAX_V = 7'(MAX_Y);

    logic [LFSR_W-1:0] lfsr_q, lfsr_d;
    logic              pending_q, pending_d;
    logic [7:0]        tgt_h_q, tgt_h_d;
    logic [6:0]        tgt_v_q, tgt_v_d;
    logic [7:0]        cand_h;
    logic [6:0]        cand_v;
    logic              cand_ok;

    always_comb begin
        cand_h  = lfsr_q[7:0];
        cand_v  = lfsr_q[14:8];
        cand_ok = (cand_h != '0) && (cand_h <= MAX_H) &&
                  (cand_v != '0) && (cand_v <= MAX_V);
        lfsr_d  = {lfsr_q[LFSR_W-2:0], lfsr_q[LFSR_TAP_HI] ^ lfsr_q[LFSR_TAP_LO]};
        // A request arriving on a load cycle keeps pending set for another draw
        pending_d = REQ | (pending_q & ~cand_ok);
        tgt_h_d   = tgt_h_q;
        tgt_v_d   = tgt_v_q;
        if (pending_q && cand_ok) begin
            tgt_h_d = cand_h;
            tgt_v_d = cand_v;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            lfsr_q    <= LFSR_SEED;
            pending_q <= 1'b0;
            tgt_h_q   <= TARGET_H_RST;
            tgt_v_q   <= TARGET_V_RST;
        end else begin
            lfsr_q    <= lfsr_d;
            pending_q <= pending_d;
            tgt_h_q   <= tgt_h_d;
            tgt_v_q   <= tgt_v_d;
        end
    end

    assign TARGET_ADDR_H = tgt_h_q;
    assign TARGET_ADDR_V = tgt_v_q;

endmodule

// File: rtl/snake_game_sequencer.sv
// Snake game master controller: game FSM, button synchronizers, heading and score.
// Define SCORE_BCD_EN to add the SCORE_BCD[11:0] output.
module snake_game_sequencer #(
    parameter int unsigned WIN_SCORE = 28,
    parameter int unsigned MAX_X     = snake_pkg::BOARD_MAX_X,
    parameter int unsigned MAX_Y     = snake_pkg::BOARD_MAX_Y,
    parameter logic [14:0] LFSR_SEED = 15'h4A5F
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        BTNU,
    input  logic        BTNL,
    input  logic        BTNR,
    input  logic        BTND,
    input  logic        BTNC,
    input  logic        TARGET_REACHED,
    input  logic        LOST,
    output logic [1:0]  MSM_STATE,
    output logic [1:0]  NAV_STATE,
    output logic        GAME_RESET,
    output logic [7:0]  TARGET_ADDR_H,
    output logic [6:0]  TARGET_ADDR_V,
    output logic [7:0]  SCORE
`ifdef SCORE_BCD_EN
    ,
    output logic [11:0] SCORE_BCD
`endif
);
    import snake_pkg::*;

    localparam logic [8:0] WIN_9 = 9'(WIN_SCORE);

    // Button vector bit order: {U, L, R, D, C}
    logic [4:0] btn_s1_q, btn_s2_q, btn_hist_q, btn_edge;
    msm_e       msm_q, msm_d;
    nav_e       nav_q, nav_d, nav_req;
    logic [1:0] nav_rev;
    logic       nav_req_vld;
    logic       game_reset_q, game_reset_d;
    logic [7:0] score_q, score_d;
    logic [8:0] score_inc;
    logic       score_clr, score_hit, target_req;
`ifdef SCORE_BCD_EN
    logic [11:0] bcd_q, bcd_d;
`endif

    assign btn_edge = btn_s2_q & ~btn_hist_q;

    always_comb begin
        msm_d      = msm_q;
        nav_d      = nav_q;
        score_clr  = 1'b0;
        score_hit  = 1'b0;
        target_req = 1'b0;
        score_inc  = {1'b0, score_q} + 9'd1;
        nav_rev    = ~nav_q;

        nav_req_vld = |btn_edge[4:1];
        if (btn_edge[4])      nav_req = NAV_UP;
        else if (btn_edge[2]) nav_req = NAV_RIGHT;
        else if (btn_edge[3]) nav_req = NAV_LEFT;
        else                  nav_req = NAV_DOWN;

        case (msm_q)
            MSM_START: begin
                nav_d = NAV_UP;
                if (btn_edge[0]) begin
                    msm_d      = MSM_PLAY;
                    score_clr  = 1'b1;
                    target_req = 1'b1;
                end
            end
            MSM_PLAY: begin
                if (TARGET_REACHED) begin
                    score_hit  = 1'b1;
                    target_req = 1'b1;
                end
                // LOST outranks WIN even when the winning hit lands the same cycle
                if (LOST)                                    msm_d = MSM_LOST;
                else if (TARGET_REACHED && score_inc == WIN_9) msm_d = MSM_WIN;
                if (nav_req_vld && nav_req != nav_rev)       nav_d = nav_req;
            end
            default: begin
                if (btn_edge[0]) begin
                    msm_d = MSM_START;
                    nav_d = NAV_UP;
                end
            end
        endcase

        score_d = score_q;
        if (score_clr)                      score_d = '0;
        else if (score_hit && !score_inc[8]) score_d = score_inc[7:0];
`ifdef SCORE_BCD_EN
        bcd_d = bcd_q;
        if (score_clr)                      bcd_d = '0;
        else if (score_hit && !score_inc[8]) bcd_d = bcd_inc(bcd_q);
`endif
        game_reset_d = (msm_d == MSM_START);
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            btn_s1_q     <= '0;
            btn_s2_q     <= '0;
            btn_hist_q   <= '0;
            msm_q        <= MSM_START;
            nav_q        <= NAV_UP;
            game_reset_q <= 1'b1;
            score_q      <= '0;
`ifdef SCORE_BCD_EN
            bcd_q        <= '0;
`endif
        end else begin
            btn_s1_q     <= {BTNU, BTNL, BTNR, BTND, BTNC};
            btn_s2_q     <= btn_s1_q;
            btn_hist_q   <= btn_s2_q;
            msm_q        <= msm_d;
            nav_q        <= nav_d;
            game_reset_q <= game_reset_d;
            score_q      <= score_d;
`ifdef SCORE_BCD_EN
            bcd_q        <= bcd_d;
`endif
        end
    end

    snake_target_lfsr #(
        .MAX_X     (MAX_X),
        .MAX_Y     (MAX_Y),
        .LFSR_SEED (LFSR_SEED)
    ) u_target (
        .CLK           (CLK),
        .RESET         (RESET),
        .REQ           (target_req),
        .TARGET_ADDR_H (TARGET_ADDR_H),
        .TARGET_ADDR_V (TARGET_ADDR_V)
    );

    assign MSM_STATE  = msm_q;
    assign NAV_STATE  = nav_q;
    assign GAME_RESET = game_reset_q;
    assign SCORE      = score_q;
`ifdef SCORE_BCD_EN
    assign SCORE_BCD  = bcd_q;
`endif

endmodule
